// File: rtl/prim_pad_wrapper_pkg.sv
// Shared pad-wrapper types: the pad attribute word and the attribute controller FSM states.
package prim_pad_wrapper_pkg;

    // Bit 0 is invert and bit 2 is pull_en, so invert|pull_en reads as 13'h005.
    typedef struct packed {
        logic [3:0] drive_strength;
        logic [1:0] slew_rate;
        logic       od_en;
        logic       schmitt_en;
        logic       keeper_en;
        logic       pull_select;
        logic       pull_en;
        logic       virt_od_en;
        logic       invert;
    } pad_attr_t;

    localparam int unsigned PadAttrW = $bits(pad_attr_t);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLD    = 2'd1,
        APPLY   = 2'd2,
        RELEASE = 2'd3
    } pad_attr_ctrl_state_e;

endpackage

// File: rtl/prim_pad_attr_ctrl.sv
// Pad attribute register bank: WARL-legalised shadow registers whose changes reach the pads
// through a freeze -> settle -> update -> settle -> release sequence, one pad at a time.
module prim_pad_attr_ctrl
    import prim_pad_wrapper_pkg::*;
#(
    parameter int unsigned NumPads      = 8,
    parameter int unsigned SettleCycles = 4,
    localparam int unsigned AddrW       = (NumPads > 1) ? $clog2(NumPads) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     req_i,
    input  logic                     we_i,
    input  logic [AddrW-1:0]         addr_i,
    input  pad_attr_t                wdata_i,
    output logic                     gnt_o,
    output logic                     rvalid_o,
    output pad_attr_t                rdata_o,
    output logic                     err_o,
    input  pad_attr_t [NumPads-1:0]  attr_warl_i,
    output pad_attr_t [NumPads-1:0]  attr_o,
    output logic [NumPads-1:0]       hold_o,
    output logic                     busy_o,
    output pad_attr_ctrl_state_e     state_o
);

    localparam int unsigned CntW = $clog2(SettleCycles + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(SettleCycles - 1);

    if (SettleCycles < 1) begin : gen_bad_settle
        $error("SettleCycles must be at least 1");
    end
    if (NumPads < 1) begin : gen_bad_numpads
        $error("NumPads must be at least 1");
    end

    pad_attr_ctrl_state_e      state_q, state_d;
    pad_attr_t [NumPads-1:0]   shadow_q, shadow_d;
    pad_attr_t [NumPads-1:0]   attr_q, attr_d;
    logic [NumPads-1:0]        hold_q, hold_d;
    logic [AddrW-1:0]          idx_q, idx_d;
    logic [CntW-1:0]           cnt_q, cnt_d;
    logic                      busy_q, busy_d;
    logic                      rvalid_q, rvalid_d;
    pad_attr_t                 rdata_q, rdata_d;
    logic                      err_q, err_d;

    logic                      gnt;
    logic                      addr_ok;
    logic [AddrW-1:0]          sel;
    pad_attr_t                 new_attr;

    // Reset is folded into the grant so a request held through reset is not acknowledged.
    assign gnt      = req_i && (state_q == IDLE) && !rst_i;
    assign addr_ok  = (32'(addr_i) < NumPads);
    assign sel      = addr_ok ? addr_i : '0;
    assign new_attr = wdata_i & attr_warl_i[sel];

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        attr_d   = attr_q;
        hold_d   = hold_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        rvalid_d = gnt;
        rdata_d  = '0;
        err_d    = 1'b0;

        if (gnt) begin
            if (!addr_ok) begin
                err_d = 1'b1;
            end else if (we_i) begin
                rdata_d = new_attr;
                // An unchanged value never disturbs the pad, so no freeze sequence is run.
                if (new_attr != shadow_q[sel]) begin
                    shadow_d[sel] = new_attr;
                    idx_d         = sel;
                    cnt_d         = '0;
                    hold_d        = '0;
                    hold_d[sel]   = 1'b1;
                    busy_d        = 1'b1;
                    state_d       = HOLD;
                end
            end else begin
                rdata_d = shadow_q[sel];
            end
        end

        case (state_q)
            HOLD: begin
                if (cnt_q == CntLast) begin
                    cnt_d   = '0;
                    state_d = APPLY;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            APPLY: begin
                attr_d[idx_q] = shadow_q[idx_q];
                cnt_d         = '0;
                state_d       = RELEASE;
            end
            RELEASE: begin
                if (cnt_q == CntLast) begin
                    cnt_d   = '0;
                    hold_d  = '0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            attr_q   <= '0;
            hold_q   <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            attr_q   <= attr_d;
            hold_q   <= hold_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign gnt_o    = gnt;
    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign err_o    = err_q;
    assign attr_o   = attr_q;
    assign hold_o   = hold_q;
    assign busy_o   = busy_q;
    assign state_o  = state_q;

    hold_onehot_a: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(hold_q));
    busy_state_a: assert property (@(posedge clk_i) disable iff (rst_i)
        busy_q == (state_q != IDLE));

    for (genvar i = 0; i < NumPads; i++) begin : gen_warl_chk
        attr_in_warl_a: assert property (@(posedge clk_i) disable iff (rst_i)
            $stable(attr_warl_i) |-> ((attr_q[i] & ~attr_warl_i[i]) == '0));
    end

endmodule
